// File: rtl/hsync_pkg.sv
// Shared types, defaults and width helpers for the line-sync front end.
package hsync_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } hsync_state_t;

   localparam int unsigned SHREG_LEN = 9;
   localparam int unsigned LINE_LEN  = 256;
   localparam int unsigned MISS_MAX  = 3;

   localparam logic [SHREG_LEN-1:0] SYNC_PATTERN = 9'b1_0000_0001;

   // Width of a counter that spans 0..line_len-1.
   function automatic int unsigned pos_width(input int unsigned line_len);
      return (line_len <= 2) ? 1 : $clog2(line_len);
   endfunction

   // Width of a counter that can hold 0..miss_max.
   function automatic int unsigned miss_width(input int unsigned miss_max);
      return (miss_max < 2) ? 1 : $clog2(miss_max + 1);
   endfunction

   localparam int unsigned POS_W  = pos_width(LINE_LEN);
   localparam int unsigned MISS_W = miss_width(MISS_MAX);

endpackage

// File: rtl/hsync_detector_if.sv
// Serial input and sync status outputs of the line-sync front end.
interface hsync_detector_if #(
   parameter int unsigned MISS_W = hsync_pkg::MISS_W
);
   logic              din;
   logic              hsync;
   logic              locked;
   logic              sync_err;
   logic [MISS_W-1:0] miss_cnt;

   modport master (
      output din,
      input  hsync,
      input  locked,
      input  sync_err,
      input  miss_cnt
   );

   modport slave (
      input  din,
      output hsync,
      output locked,
      output sync_err,
      output miss_cnt
   );
endinterface

// File: rtl/hsync_detector_sync_shreg.sv
// Serial shift register with a combinational compare against the sync pattern.
module sync_shreg
   import hsync_pkg::*;
#(
   parameter int unsigned        LEN     = hsync_pkg::SHREG_LEN,
   parameter logic [LEN-1:0]     PATTERN = LEN'(hsync_pkg::SYNC_PATTERN)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_din,
   output logic o_match_c
);

   logic [LEN-1:0] r_shreg;

   // Oldest bit ends up in the MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg <= '0;
      end else begin
         r_shreg <= {r_shreg[LEN-2:0], i_din};
      end
   end

   assign o_match_c = (r_shreg == PATTERN);

endmodule

// File: rtl/hsync_detector.sv
// Line-sync qualifier: locks onto the sync pattern at a fixed line period and
// flywheels over up to MISS_MAX-1 consecutive missing syncs.
module hsync_detector
   import hsync_pkg::*;
#(
   parameter int unsigned              SHREG_LEN    = hsync_pkg::SHREG_LEN,
   parameter logic [SHREG_LEN-1:0]     SYNC_PATTERN = SHREG_LEN'(hsync_pkg::SYNC_PATTERN),
   parameter int unsigned              LINE_LEN     = hsync_pkg::LINE_LEN,
   parameter int unsigned              MISS_MAX     = hsync_pkg::MISS_MAX
) (
   input  logic              clk,
   input  logic              rst,
   hsync_detector_if.slave   bus
);

   localparam int unsigned POS_W = pos_width(LINE_LEN);
   localparam int unsigned CNT_W = miss_width(MISS_MAX);

   localparam logic [POS_W-1:0] POS_LAST  = POS_W'(LINE_LEN - 1);
   localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_MAX - 1);

   hsync_state_t     r_state;
   logic [POS_W-1:0] r_pos;
   logic [CNT_W-1:0] r_miss_cnt;
   logic             r_hsync;
   logic             r_locked;
   logic             r_sync_err;

   logic             w_match;
   logic             w_slot;

   sync_shreg #(
      .LEN     (SHREG_LEN),
      .PATTERN (SYNC_PATTERN)
   ) u_sync_shreg (
      .clk       (clk),
      .rst       (rst),
      .i_din     (bus.din),
      .o_match_c (w_match)
   );

   assign w_slot = (r_pos == POS_LAST);

   // Lock FSM; pulses default low every cycle and are raised only where needed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= HUNT;
         r_pos      <= '0;
         r_miss_cnt <= '0;
         r_hsync    <= 1'b0;
         r_locked   <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_hsync    <= 1'b0;
         r_sync_err <= 1'b0;
         case (r_state)
            HUNT: begin
               r_pos <= '0;
               if (w_match) begin
                  r_state    <= LOCK;
                  r_hsync    <= 1'b1;
                  r_miss_cnt <= '0;
                  r_locked   <= 1'b1;
               end
            end
            LOCK: begin
               if (w_slot) begin
                  r_pos <= '0;
                  if (w_match) begin
                     r_hsync    <= 1'b1;
                     r_miss_cnt <= '0;
                  end else if (r_miss_cnt == MISS_LAST) begin
                     r_state    <= HUNT;
                     r_miss_cnt <= '0;
                     r_locked   <= 1'b0;
                  end else begin
                     // Flywheel: keep the line timing running on a missing sync.
                     r_hsync    <= 1'b1;
                     r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                  end
               end else begin
                  r_pos      <= r_pos + POS_W'(1);
                  r_sync_err <= w_match;
               end
            end
            default: begin
               r_state  <= HUNT;
               r_pos    <= '0;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hsync    = r_hsync;
   assign bus.locked   = r_locked;
   assign bus.sync_err = r_sync_err;
   assign bus.miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_hsync_detector.sv
// Scoreboard bench for hsync_detector: directed line sequences with expected output events.
module tb_hsync_detector;
   import hsync_pkg::*;

   typedef struct packed {
      int         cyc;
      logic       hs;
      logic       se;
      logic       lk;
      logic [1:0] mc;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc = 0;

   ev_t   q[$];
   string nq[$];

   logic snap_req   = 1'b0;
   logic done       = 1'b0;
   logic final_done = 1'b0;
   int   n_checks   = 0;
   int   n_errors   = 0;
   int   n;

   hsync_detector_if bus ();

   hsync_detector dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input logic b);
      bus.din = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) step(1'b0);
   endtask

   task automatic send_pat();
      logic [SHREG_LEN-1:0] p;
      p = SYNC_PATTERN;
      for (int i = SHREG_LEN - 1; i >= 0; i--) step(p[i]);
   endtask

   task automatic line(input bit with_sync);
      if (with_sync) begin
         idle(LINE_LEN - SHREG_LEN);
         send_pat();
      end else begin
         idle(LINE_LEN);
      end
   endtask

   task automatic expect_ev(input string nm, input int c, input logic hs, input logic se,
                            input logic lk, input logic [1:0] mc);
      ev_t e;
      e.cyc = c; e.hs = hs; e.se = se; e.lk = lk; e.mc = mc;
      q.push_back(e);
      nq.push_back(nm);
   endtask

   // Force the monitor to sample the current cycle even with no output activity.
   task automatic snapshot(input string nm);
      expect_ev(nm, cyc, 1'b0, 1'b0, 1'b0, 2'd0);
      snap_req = 1'b1;
      @(negedge clk);
      #1;
      snap_req = 1'b0;
   endtask

   // Monitor: any pulse or status change is an output event popped from the scoreboard.
   initial begin : monitor
      logic       prev_lk;
      logic [1:0] prev_mc;
      ev_t        e;
      string      nm;
      prev_lk = 1'b0;
      prev_mc = 2'd0;
      forever begin
         @(negedge clk);
         if (snap_req || bus.hsync || bus.sync_err ||
             bus.locked != prev_lk || bus.miss_cnt != prev_mc) begin
            n_checks++;
            if (q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_event: got cyc=%0d hs=%0b se=%0b lk=%0b mc=%0d, expected no event",
                        cyc, bus.hsync, bus.sync_err, bus.locked, bus.miss_cnt);
            end else begin
               e  = q.pop_front();
               nm = nq.pop_front();
               if (e.cyc != cyc || e.hs !== bus.hsync || e.se !== bus.sync_err ||
                   e.lk !== bus.locked || e.mc !== bus.miss_cnt) begin
                  n_errors++;
                  $display("FAIL %s: got cyc=%0d hs=%0b se=%0b lk=%0b mc=%0d, expected cyc=%0d hs=%0b se=%0b lk=%0b mc=%0d",
                           nm, cyc, bus.hsync, bus.sync_err, bus.locked, bus.miss_cnt,
                           e.cyc, e.hs, e.se, e.lk, e.mc);
               end
            end
         end
         prev_lk = bus.locked;
         prev_mc = bus.miss_cnt;
         if (done && !final_done) begin
            n_checks++;
            if (q.size() != 0) begin
               n_errors++;
               $display("FAIL missing_events: got %0d events never seen, expected 0 (first: %s)",
                        q.size(), nq[0]);
            end
            final_done = 1'b1;
         end
      end
   end

   initial begin : stimulus
      rst     = 1'b1;
      bus.din = 1'b0;
      idle(3);
      rst = 1'b0;
      snapshot("reset_state");

      idle(300);
      snapshot("hunt_quiet");

      // First lock and three further good lines.
      send_pat();
      n = cyc;
      expect_ev("first_lock", n + 1, 1'b1, 1'b0, 1'b1, 2'd0);
      for (int k = 1; k <= 3; k++) begin
         line(1'b1);
         expect_ev($sformatf("line%0d", k), n + 256 * k + 1, 1'b1, 1'b0, 1'b1, 2'd0);
      end
      n = n + 768;

      // Two misses recovered by a good sync.
      line(1'b0);
      expect_ev("fly1", n + 257, 1'b1, 1'b0, 1'b1, 2'd1);
      line(1'b0);
      expect_ev("fly2", n + 513, 1'b1, 1'b0, 1'b1, 2'd2);
      line(1'b1);
      expect_ev("resync", n + 769, 1'b1, 1'b0, 1'b1, 2'd0);
      n = n + 768;

      // Three misses drop lock.
      line(1'b0);
      expect_ev("fly1b", n + 257, 1'b1, 1'b0, 1'b1, 2'd1);
      line(1'b0);
      expect_ev("fly2b", n + 513, 1'b1, 1'b0, 1'b1, 2'd2);
      line(1'b0);
      expect_ev("drop_lock", n + 769, 1'b0, 1'b0, 1'b0, 2'd0);

      // Relock, then a spurious pattern at pos 100.
      idle(10);
      send_pat();
      n = cyc;
      expect_ev("relock", n + 1, 1'b1, 1'b0, 1'b1, 2'd0);
      idle(92);
      send_pat();
      expect_ev("spurious", n + 102, 1'b0, 1'b1, 1'b1, 2'd0);
      idle(LINE_LEN - 101 - SHREG_LEN);
      send_pat();
      expect_ev("after_spur", n + 257, 1'b1, 1'b0, 1'b1, 2'd0);
      n = cyc;

      // Reset at pos 50 while the pattern sits in the shift register.
      idle(42);
      send_pat();
      expect_ev("reset_mid", n + 52, 1'b0, 1'b0, 1'b0, 2'd0);
      rst = 1'b1;
      step(1'b0);
      rst = 1'b0;

      // Bits that would complete a match early if the shift register kept stale data.
      idle(6);
      step(1'b1);
      idle(7);
      step(1'b1);
      expect_ev("relock_rst", n + 68, 1'b1, 1'b0, 1'b1, 2'd0);

      idle(20);
      done = 1'b1;
      repeat (3) @(posedge clk);
      if (!final_done) $display("FAIL final_check: got not reached, expected reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hsync_detector.md
# hsync_detector

Serial line-sync front end. Shifts the incoming serial bit stream through a 9-bit shift register and matches a fixed sync pattern. Qualifies each match against the expected line period, with flywheel recovery for missed syncs. Emits a clean one-cycle `hsync` pulse that drives the reset input of the downstream `global_counter` (DWIDTH = 8), restarting that counter once per line.

## Interface
- `SHREG_LEN`, 9: shift-register length in bits.
- `SYNC_PATTERN`, 9'b1_0000_0001: pattern that marks a line start (`shreg[8]` is the oldest bit).
- `LINE_LEN`, 256: cycles between consecutive syncs; must equal 2**DWIDTH of `global_counter`.
- `MISS_MAX`, 3: consecutive missed syncs tolerated before lock is dropped.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  1  serial data, sampled every posedge.
- `hsync`  out  1  registered one-cycle line-start pulse to `global_counter.rst`.
- `locked`  out  1  high while in LOCK state.
- `sync_err`  out  1  one-cycle pulse: pattern matched outside the expected slot while locked.
- `miss_cnt`  out  $clog2(MISS_MAX+1)  current consecutive-miss count.

## Operation
- Every cycle: `shreg <= {shreg[SHREG_LEN-2:0], din}`. `match = (shreg == SYNC_PATTERN)`, combinational on the registered `shreg`.
- `pos`: $clog2(LINE_LEN)-bit position counter. `slot = (pos == LINE_LEN-1)`.
- States: HUNT, LOCK.
- HUNT:
  - On `match`: register `hsync`=1, `pos`<=0, `miss_cnt`<=0, go to LOCK.
  - Otherwise `pos` holds at 0 and `hsync`=0.
- LOCK, per cycle:
  - `slot & match`: good sync. `hsync`=1, `pos`<=0, `miss_cnt`<=0.
  - `slot & !match`: miss. If `miss_cnt`+1 == MISS_MAX, go to HUNT with `hsync`=0, `pos`<=0, `miss_cnt`<=0. Otherwise flywheel: `hsync`=1, `pos`<=0, `miss_cnt`++.
  - `!slot & match`: spurious. `sync_err`=1 for one cycle; `pos`++; no `hsync`.
  - `!slot & !match`: `pos`++.
- `locked` = (state == LOCK), registered.
- Arithmetic:
  - `pos` wraps only via an explicit load of 0 at the slot and never overflows.
  - `miss_cnt` saturates at MISS_MAX-1 and is never reported as MISS_MAX.

## Timing
- Reset values: `shreg`=0, `pos`=0, `miss_cnt`=0, state HUNT, `hsync`=0, `locked`=0, `sync_err`=0.
- Reset wins over every simultaneous event.
- Reset mid-line: the next cycle is HUNT with a cleared `shreg`, so at least SHREG_LEN new bits are needed before a match.
- Latency: the last pattern bit is sampled at edge N and `shreg` matches after edge N. `hsync` and the LOCK transition are registered at edge N+1, and `hsync` is high for exactly one cycle.
- In LOCK, `hsync` pulses are exactly LINE_LEN cycles apart, including flywheel pulses.
- `locked` rises in the same cycle as the first `hsync`. It falls in the cycle after the edge that consumes the final miss, and no `hsync` accompanies the fall.
- `sync_err` and `hsync` are never high in the same cycle.
- Downstream contract: each `hsync` high cycle resets `global_counter`. That counter then runs one full 0..255 pass per line.

## Structure
- Package `hsync_pkg`:
  - state enum `hsync_state_t` {HUNT, LOCK};
  - default `SYNC_PATTERN` constant;
  - function returning the `pos`/`miss_cnt` widths.
- Sub-module `sync_shreg`:
  - parameterised shift register plus pattern compare;
  - outputs `match`;
  - reset clears contents.
- Top level holds the FSM, `pos`, `miss_cnt` and the output registers.

## Test plan
- Reset, then feed `din`=0 for 300 cycles -> `hsync`, `locked` and `sync_err` stay 0, state HUNT.
- Feed 1,0,0,0,0,0,0,0,1 after reset -> `hsync` high for exactly one cycle, one edge after the final `1` is sampled; `locked`=1; `global_counter` counter=0 then counts.
- Repeat the pattern every 256 cycles for 4 lines -> 4 `hsync` pulses at 256-cycle spacing, `miss_cnt`=0, `sync_err`=0.
- While locked, omit syncs 2 and 3 -> flywheel `hsync` at 256-cycle spacing with `miss_cnt` 1 then 2. Omit sync 4 as well -> `locked`=0, no `hsync`, state HUNT.
- While locked, inject the pattern at `pos`=100 -> `sync_err` pulses once, no `hsync`, next `hsync` still at `pos`=255 slot.
- Assert `rst` at `pos`=50 with the pattern in `shreg` -> all outputs 0 next cycle. A fresh pattern 9 bits later re-locks.
